// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch sequencer.
//   ifetch_state_t : sequencer state (PRIME, FETCH, EXEC, SETTLE)
//   OP_J*          : conditional-jump opcodes that need two program counter enables
//   NOP_WORD       : instruction substituted when memory never answers
//   exec_count()   : number of pc_en cycles an opcode needs
package ifetch_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_SETTLE = 2'd3
  } ifetch_state_t;

  localparam logic [3:0] OP_JZE = 4'b1001;
  localparam logic [3:0] OP_JNE = 4'b1010;
  localparam logic [3:0] OP_JCY = 4'b1011;

  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

  // Conditional jumps step the program counter twice (evaluate, then load).
  function automatic logic [1:0] exec_count(input logic [3:0] op);
    if (op == OP_JZE || op == OP_JNE || op == OP_JCY) begin
      return 2'd2;
    end
    return 2'd1;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: program memory read port.
//   mem_req   : read request (fetcher -> memory)
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : read data valid this cycle (memory -> fetcher)
//   mem_rdata : read data, sampled in the cycle mem_ack is high
//
// Handshake: the fetcher raises mem_req with mem_addr and holds both steady
// until it sees mem_ack=1 at a rising edge (transfer happens on that edge) or
// its watchdog gives up. mem_ack is meaningful only while mem_req=1; an ack
// seen with mem_req=0 is ignored. mem_req drops in the cycle after the
// transfer, so each request completes at most one transfer.
interface ifetch_if;
  import ifetch_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/ifetch_wdog.sv
// ifetch_wdog: saturating request watchdog.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (held while the sequencer settles)
//   inc        : one more cycle waited without an ack
//   expired    : this waiting cycle is the TIMEOUT-th one; give up now
module ifetch_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int         W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of already-completed waiting cycles, so the cycle
  // in which it equals TIMEOUT-1 is the last one the request may stay up.
  assign expired = inc && (count == LAST);

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch sequencer ahead of the program counter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : global run enable
//   pc         : current program counter, sampled only in SETTLE
//   mem        : program memory read port (master side)
//   ir         : instruction register
//   ir_valid   : ir holds a completed fetch
//   pc_en      : registered enable to the program counter
//   fetch_err  : sticky watchdog flag
//   state      : current sequencer state, for observation
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP     = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  ifetch_if.master          mem,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              pc_en,
  output logic              fetch_err,
  output ifetch_state_t     state
);

  logic [1:0] exec_cnt;
  logic       wd_clr;
  logic       wd_inc;
  logic       wd_expired;

  assign wd_clr = (state == ST_SETTLE);
  assign wd_inc = (state == ST_FETCH) && !mem.mem_ack;

  ifetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // pc_en is a register: the value loaded at an edge is what the program
  // counter sees during the following cycle. In PRIME and EXEC it is loaded
  // from en, so a cycle with en=0 simply produces no enable and the count
  // only moves in cycles where pc_en is actually high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_PRIME;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      ir            <= '0;
      ir_valid      <= 1'b0;
      pc_en         <= 1'b0;
      fetch_err     <= 1'b0;
      exec_cnt      <= '0;
    end else begin
      case (state)
        ST_PRIME: begin
          if (pc_en) begin
            pc_en <= 1'b0;
            state <= ST_SETTLE;
          end else begin
            pc_en <= en;
          end
        end

        ST_SETTLE: begin
          if (en) begin
            mem.mem_addr <= pc;
            mem.mem_req  <= 1'b1;
            state        <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          // An ack in the expiry cycle still delivers real data.
          if (mem.mem_ack) begin
            ir          <= mem.mem_rdata;
            ir_valid    <= 1'b1;
            mem.mem_req <= 1'b0;
            exec_cnt    <= exec_count(mem.mem_rdata[DATA_W-1:DATA_W-4]);
            pc_en       <= en;
            state       <= ST_EXEC;
          end else if (wd_expired) begin
            ir          <= NOP;
            ir_valid    <= 1'b1;
            fetch_err   <= 1'b1;
            mem.mem_req <= 1'b0;
            exec_cnt    <= 2'd1;
            pc_en       <= en;
            state       <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (pc_en) begin
            if (exec_cnt == 2'd1) begin
              exec_cnt <= 2'd0;
              pc_en    <= 1'b0;
              state    <= ST_SETTLE;
            end else begin
              exec_cnt <= exec_cnt - 2'd1;
              pc_en    <= en;
            end
          end else begin
            pc_en <= en;
          end
        end

        default: begin
          state <= ST_PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized bench for ifetch with a transaction-level model.
// A simple program counter model steps on pc_en; the scoreboard predicts the
// fetch address, instruction, request length, enable count and error flag.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [11:0]   pc;
  logic [15:0]   ir;
  logic          ir_valid;
  logic          pc_en;
  logic          fetch_err;
  ifetch_state_t state;

  ifetch_if mem ();

  ifetch #(.TIMEOUT(TIMEOUT), .NOP(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pc        (pc),
    .mem       (mem),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc_en     (pc_en),
    .fetch_err (fetch_err),
    .state     (state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) pc <= 12'd0;
    else if (pc_en) pc <= pc + 12'd1;
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [11:0] exp_pc;
  logic        exp_err;
  logic [15:0] last_ir;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(mem.mem_req), 0);
    check({tag, "_addr"},  32'(mem.mem_addr), 0);
    check({tag, "_ir"},    32'(ir), 0);
    check({tag, "_valid"}, 32'(ir_valid), 0);
    check({tag, "_pc_en"}, 32'(pc_en), 0);
    check({tag, "_err"},   32'(fetch_err), 0);
  endtask

  // After reset release with en=1: exactly one arming pulse on pc_en.
  task automatic prime();
    int waited = 0;
    while (!pc_en && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("prime_pulse", 32'(pc_en), 1);
    @(negedge clk);
    check("prime_width", 32'(pc_en), 0);
    exp_pc = 12'd1;
  endtask

  // One full instruction: request (with 'delay' wait cycles before ack, or
  // none at all if delay >= TIMEOUT), then the execute/settle window in
  // which en may be dropped for 'gap' cycles after the first pc_en.
  task automatic do_fetch(input logic [15:0] data, input int delay, input int gap,
                          input bit en_rand);
    int          waited = 0;
    int          req_cycles = 0;
    int          pulses = 0;
    int          low_pulses = 0;
    int          t = 0;
    int          last_pulse_t = 0;
    int          gap_left = 0;
    int          exp_pulses;
    bit          timed_out;
    logic        en_prev;
    logic [15:0] exp_ir;

    timed_out = (delay >= TIMEOUT);
    exp_q.push_back(timed_out ? NOP_WORD : data);
    if (timed_out) exp_pulses = 1;
    else if (data[15:12] == 4'h9 || data[15:12] == 4'hA || data[15:12] == 4'hB) exp_pulses = 2;
    else exp_pulses = 1;

    while (!mem.mem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!mem.mem_req) begin
      check("req_start", 0, 1);
      return;
    end

    while (mem.mem_req && req_cycles < 100) begin
      req_cycles++;
      check("mem_addr", 32'(mem.mem_addr), 32'(exp_pc));
      check("ir_hold", 32'(ir), 32'(last_ir));
      mem.mem_ack   = (req_cycles == delay + 1);
      mem.mem_rdata = mem.mem_ack ? data : 16'($urandom);
      if (en_rand) en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    mem.mem_ack = 1'b0;
    en_prev = en;
    en = 1'b1;

    check("req_cycles", 32'(req_cycles), 32'(timed_out ? TIMEOUT : delay + 1));
    exp_ir = exp_q.pop_front();
    if (timed_out) exp_err = 1'b1;
    check("ir", 32'(ir), 32'(exp_ir));
    check("ir_valid", 32'(ir_valid), 1);
    check("fetch_err", 32'(fetch_err), 32'(exp_err));
    last_ir = exp_ir;

    while (!mem.mem_req && t < 100) begin
      if (pc_en) begin
        pulses++;
        last_pulse_t = t;
        if (!en_prev) low_pulses++;
      end
      check("ir_exec", 32'(ir), 32'(last_ir));
      if (pc_en && pulses == 1 && gap > 0 && gap_left == 0) begin
        en = 1'b0;
        gap_left = gap;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) en = 1'b1;
      end
      en_prev = en;
      mem.mem_ack   = 1'($urandom_range(0, 1));
      mem.mem_rdata = 16'($urandom);
      @(negedge clk);
      t++;
    end
    if (!mem.mem_req) check("exec_window", 0, 1);
    check("pc_en_pulses", 32'(pulses), 32'(exp_pulses));
    check("pulse_en_low", 32'(low_pulses), 0);
    if (gap == 0) check("settle_gap", 32'(t - last_pulse_t), 2);
    else check("settle_min", 32'(t - last_pulse_t >= 2), 1);
    exp_pc = 12'(exp_pc + 12'(exp_pulses));
  endtask

  task automatic random_fetch();
    logic [15:0] data;
    int          delay;
    int          gap;
    data  = {4'($urandom_range(0, 15)), 12'($urandom)};
    delay = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, 5));
    gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    do_fetch(data, delay, gap, 1'($urandom_range(0, 1)));
  endtask

  // Reset in the middle of a request; a late ack must not land.
  task automatic reset_mid_fetch();
    int waited = 0;
    while (!mem.mem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("rst_req_seen", 32'(mem.mem_req), 1);
    mem.mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    check("rst_state", 32'(state), 32'(ST_PRIME));
    en = 1'b0;
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 16'hBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_ir", 32'(ir), 0);
      check("late_ack_valid", 32'(ir_valid), 0);
      check("late_ack_req", 32'(mem.mem_req), 0);
      check("idle_pc_en", 32'(pc_en), 0);
    end
    mem.mem_ack = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    last_ir = 16'h0000;
    en = 1'b1;
    prime();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 16'h0000;
    exp_pc  = 12'd0;
    exp_err = 1'b0;
    last_ir = 16'h0000;
    rst_n   = 1'b0;
    en      = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    prime();

    do_fetch(16'h1234, 0, 0, 1'b0);
    do_fetch(16'h9005, 0, 0, 1'b0);
    do_fetch(16'h8005, 0, 0, 1'b0);
    do_fetch(16'h5A5A, 3, 0, 1'b0);
    do_fetch(16'hB777, TIMEOUT - 1, 0, 1'b0);
    do_fetch(16'h4321, TIMEOUT, 0, 1'b0);
    do_fetch(16'hA123, 0, 3, 1'b0);
    do_fetch(16'h2222, 1, 2, 1'b1);

    for (int i = 0; i < 40; i++) random_fetch();

    reset_mid_fetch();
    do_fetch(16'h9ABC, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) random_fetch();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
